// File: rtl/matrix_pkg.sv
// ============================================================================
// matrix_pkg : shared widths, streamer FSM encoding and stream beat tag type
// Rev 1.0
// ============================================================================
`default_nettype none

package matrix_pkg;

   localparam int MATRIX_ID_WIDTH = 3;
   localparam int DIM_WIDTH       = 8;
   localparam int NAME_WIDTH      = 64;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_REQ       = 3'd1,
      ST_WAIT_META = 3'd2,
      ST_FETCH     = 3'd3,
      ST_WAIT_DATA = 3'd4,
      ST_DRAIN     = 3'd5,
      ST_ABORT     = 3'd6
   } stream_state_t;

   // Position tag carried alongside each element; the data field is width-parameterised
   // by the streamer, so the full beat struct is assembled there.
   typedef struct packed {
      logic [DIM_WIDTH-1:0] row;
      logic [DIM_WIDTH-1:0] col;
      logic                 last;
   } beat_tag_t;

   function automatic logic is_last_elem(input logic [DIM_WIDTH-1:0] row,
                                         input logic [DIM_WIDTH-1:0] col,
                                         input logic [DIM_WIDTH-1:0] rows,
                                         input logic [DIM_WIDTH-1:0] cols);
      return (row == rows - 8'd1) && (col == cols - 8'd1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_read_streamer_if.sv
// ============================================================================
// matrix_read_streamer_if : command, manager read port, metadata and output stream
// Rev 1.0
// ============================================================================
`default_nettype none

interface matrix_read_streamer_if
   import matrix_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) ();

   logic                       cmd_valid;
   logic [MATRIX_ID_WIDTH-1:0] cmd_matrix_id;
   logic                       cmd_ready;

   logic                       reader_ready;
   logic                       read_req;
   logic [MATRIX_ID_WIDTH-1:0] read_matrix_id;
   logic                       read_meta_valid;
   logic [DIM_WIDTH-1:0]       read_rows;
   logic [DIM_WIDTH-1:0]       read_cols;
   logic [NAME_WIDTH-1:0]      read_matrix_name;
   logic                       read_data_req;
   logic [DATA_WIDTH-1:0]      read_data_out;
   logic                       read_data_valid;
   logic                       read_done;

   logic                       meta_valid;
   logic [DIM_WIDTH-1:0]       meta_rows;
   logic [DIM_WIDTH-1:0]       meta_cols;
   logic [NAME_WIDTH-1:0]      meta_name;

   logic                       out_valid;
   logic                       out_ready;
   logic [DATA_WIDTH-1:0]      out_data;
   logic [DIM_WIDTH-1:0]       out_row;
   logic [DIM_WIDTH-1:0]       out_col;
   logic                       out_last;

   modport master (
      input  cmd_valid, cmd_matrix_id, reader_ready, read_meta_valid, read_rows,
             read_cols, read_matrix_name, read_data_out, read_data_valid, read_done,
             out_ready,
      output cmd_ready, read_req, read_matrix_id, read_data_req, meta_valid,
             meta_rows, meta_cols, meta_name, out_valid, out_data, out_row,
             out_col, out_last
   );

   modport slave (
      output cmd_valid, cmd_matrix_id, reader_ready, read_meta_valid, read_rows,
             read_cols, read_matrix_name, read_data_out, read_data_valid, read_done,
             out_ready,
      input  cmd_ready, read_req, read_matrix_id, read_data_req, meta_valid,
             meta_rows, meta_cols, meta_name, out_valid, out_data, out_row,
             out_col, out_last
   );

endinterface

`default_nettype wire

// File: rtl/matrix_stream_fifo.sv
// ============================================================================
// matrix_stream_fifo : synchronous FIFO of stream beats with occupancy count
// Rev 1.0
// ============================================================================
`default_nettype none

module matrix_stream_fifo #(
   parameter int WIDTH = 49,
   parameter int DEPTH = 4
) (
   input  wire logic                     clk,
   input  wire logic                     rst,
   input  wire logic                     i_flush,
   input  wire logic                     i_push,
   input  wire logic [WIDTH-1:0]         i_data,
   input  wire logic                     i_pop,
   output logic      [WIDTH-1:0]         o_data,
   output logic                          o_empty,
   output logic                          o_full,
   output logic      [$clog2(DEPTH):0]   o_count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [PTR_W:0]   r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rptr];
   assign w_do_pop  = i_pop && !o_empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush) r_mem[r_wptr] <= i_data;
   end

endmodule

`default_nettype wire

// File: rtl/matrix_read_streamer.sv
// ============================================================================
// matrix_read_streamer : drives the storage manager read handshake and re-emits
// the matrix row-major as a tagged valid/ready stream.  Rev 1.0
// ============================================================================
`default_nettype none

module matrix_read_streamer
   import matrix_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  wire logic              clk,
   input  wire logic              rst,
   matrix_read_streamer_if.master bus,
   output logic                   busy,
   output logic                   error
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      beat_tag_t             tag;
   } beat_t;

   stream_state_t              r_state, w_state_next;
   logic [MATRIX_ID_WIDTH-1:0] r_id;
   logic [DIM_WIDTH-1:0]       r_rows, r_cols, r_row, r_col;
   logic [NAME_WIDTH-1:0]      r_name;
   logic                       r_meta_valid;
   logic                       r_done_seen;
   logic                       r_error;
   logic [TMO_W-1:0]           r_tmo;

   logic                       w_read_req, w_data_req, w_flush, w_waiting, w_timeout;
   logic                       w_push, w_pop, w_empty, w_full, w_last;
   logic [CNT_W-1:0]           w_fifo_count;
   beat_t                      w_in_beat, w_head;

   assign w_waiting = (r_state == ST_REQ) || (r_state == ST_WAIT_META) ||
                      (r_state == ST_WAIT_DATA);
   assign w_timeout = w_waiting && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
   assign w_last    = is_last_elem(r_row, r_col, r_rows, r_cols);
   assign w_push    = (r_state == ST_WAIT_DATA) && bus.read_data_valid;
   assign w_pop     = bus.out_ready && !w_empty;

   always_comb begin
      w_state_next = r_state;
      w_read_req   = 1'b0;
      w_data_req   = 1'b0;
      w_flush      = 1'b0;
      case (r_state)
         ST_IDLE: if (bus.cmd_valid) w_state_next = ST_REQ;
         ST_REQ: begin
            if (bus.reader_ready) begin
               w_read_req   = 1'b1;
               w_state_next = ST_WAIT_META;
            end else if (w_timeout) begin
               w_state_next = ST_ABORT;
            end
         end
         ST_WAIT_META: begin
            if (bus.read_meta_valid)
               w_state_next = ((bus.read_rows == '0) || (bus.read_cols == '0)) ?
                              ST_DRAIN : ST_FETCH;
            else if (w_timeout)
               w_state_next = ST_ABORT;
         end
         ST_FETCH: begin
            // Only one request is ever in flight, so room for one more beat suffices.
            if (w_fifo_count < CNT_W'(FIFO_DEPTH)) begin
               w_data_req   = 1'b1;
               w_state_next = ST_WAIT_DATA;
            end
         end
         ST_WAIT_DATA: begin
            if (bus.read_data_valid)      w_state_next = w_last ? ST_DRAIN : ST_FETCH;
            else if (w_timeout)           w_state_next = ST_ABORT;
         end
         ST_DRAIN: if (w_empty && (r_done_seen || bus.read_done)) w_state_next = ST_IDLE;
         ST_ABORT: begin
            w_flush      = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_id         <= '0;
         r_rows       <= '0;
         r_cols       <= '0;
         r_name       <= '0;
         r_meta_valid <= 1'b0;
         r_row        <= '0;
         r_col        <= '0;
         r_done_seen  <= 1'b0;
         r_error      <= 1'b0;
         r_tmo        <= '0;
      end else begin
         r_state      <= w_state_next;
         r_meta_valid <= (r_state == ST_WAIT_META) && bus.read_meta_valid;
         r_tmo        <= (w_state_next != r_state) ? '0 : r_tmo + TMO_W'(1);
         if (r_state == ST_IDLE && bus.cmd_valid) begin
            r_id        <= bus.cmd_matrix_id;
            r_error     <= 1'b0;
            r_done_seen <= 1'b0;
            r_row       <= '0;
            r_col       <= '0;
         end else begin
            if (bus.read_done && r_state != ST_IDLE) r_done_seen <= 1'b1;
            if (w_state_next == ST_ABORT)            r_error     <= 1'b1;
         end
         if (r_state == ST_WAIT_META && bus.read_meta_valid) begin
            r_rows <= bus.read_rows;
            r_cols <= bus.read_cols;
            r_name <= bus.read_matrix_name;
         end
         if (w_push) begin
            if (r_col == r_cols - 8'd1) begin
               r_col <= '0;
               r_row <= r_row + 8'd1;
            end else begin
               r_col <= r_col + 8'd1;
            end
         end
      end
   end

   assign w_in_beat.data     = bus.read_data_out;
   assign w_in_beat.tag.row  = r_row;
   assign w_in_beat.tag.col  = r_col;
   assign w_in_beat.tag.last = w_last;

   matrix_stream_fifo #(
      .WIDTH ($bits(beat_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (w_flush),
      .i_push  (w_push),
      .i_data  (w_in_beat),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_empty (w_empty),
      .o_full  (w_full),
      .o_count (w_fifo_count)
   );

   assign bus.cmd_ready      = (r_state == ST_IDLE);
   assign bus.read_req       = w_read_req;
   assign bus.read_matrix_id = r_id;
   assign bus.read_data_req  = w_data_req;
   assign bus.meta_valid     = r_meta_valid;
   assign bus.meta_rows      = r_rows;
   assign bus.meta_cols      = r_cols;
   assign bus.meta_name      = r_name;
   assign bus.out_valid      = !w_empty;
   assign bus.out_data       = w_head.data;
   assign bus.out_row        = w_head.tag.row;
   assign bus.out_col        = w_head.tag.col;
   assign bus.out_last       = w_head.tag.last;
   assign busy               = (r_state != ST_IDLE);
   assign error              = r_error;

endmodule

`default_nettype wire

// File: tb/tb_matrix_read_streamer.sv
// ============================================================================
// tb_matrix_read_streamer : directed bench with a behavioural storage manager
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_matrix_read_streamer;
   import matrix_pkg::*;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int TMO   = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy, error;

   matrix_read_streamer_if #(.DATA_WIDTH(DW)) bus ();

   matrix_read_streamer #(
      .DATA_WIDTH     (DW),
      .FIFO_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus.master),
      .busy  (busy),
      .error (error)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Manager slot contents
   logic [7:0]  s_rows [8];
   logic [7:0]  s_cols [8];
   logic [63:0] s_name [8];
   bit          s_silent [8];

   int          ready_mode;   // 0: never ready, 1: always ready, 2: ready 1 of 3 cycles
   int          cyc = 0;
   bit          meta_due, data_due, done_due;
   int          m_slot, m_idx;
   int          occ, pend_push, pend_pop;
   logic [63:0] rcv [$];
   int          meta_cnt, req_cnt, dreq_cnt, overfill, stab_viol;
   logic [7:0]  got_rows, got_cols;
   logic [63:0] got_name;
   bit          prev_stall;
   logic [63:0] held;

   function automatic logic [31:0] elem_val(input int slot, input int i);
      return (slot == 1) ? 32'((i + 1) * 10) : 32'(i + 1);
   endfunction

   // Storage manager model and stream monitor, all on the falling edge.
   always @(negedge clk) begin
      logic [63:0] beat;
      cyc++;
      if (rst) begin
         meta_due = 0; data_due = 0; done_due = 0;
         occ = 0; pend_push = 0; pend_pop = 0; prev_stall = 0;
         bus.read_meta_valid = 1'b0;
         bus.read_data_valid = 1'b0;
         bus.read_done       = 1'b0;
         bus.read_data_out   = '0;
         bus.out_ready       = 1'b0;
      end else begin
         occ = occ + pend_push - pend_pop;
         case (ready_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = (cyc % 3 == 0);
         endcase
         beat = 64'({bus.out_data, bus.out_row, bus.out_col, bus.out_last});
         if (prev_stall && (!bus.out_valid || beat != held)) stab_viol++;
         prev_stall = bus.out_valid && !bus.out_ready;
         held       = beat;
         if (bus.out_valid && bus.out_ready) rcv.push_back(beat);
         pend_pop = (bus.out_valid && bus.out_ready) ? 1 : 0;
         if (bus.meta_valid) begin
            meta_cnt++;
            got_rows = bus.meta_rows;
            got_cols = bus.meta_cols;
            got_name = bus.meta_name;
         end
         if (bus.read_req) req_cnt++;
         if (bus.read_data_req) begin
            dreq_cnt++;
            if (occ >= DEPTH) overfill++;
         end

         bus.read_meta_valid  = meta_due;
         bus.read_rows        = s_rows[m_slot];
         bus.read_cols        = s_cols[m_slot];
         bus.read_matrix_name = s_name[m_slot];
         bus.read_data_valid  = data_due && !s_silent[m_slot];
         bus.read_data_out    = '0;
         if (bus.read_data_valid) begin
            bus.read_data_out = elem_val(m_slot, m_idx);
            m_idx++;
         end
         bus.read_done = done_due;
         done_due = 0;
         if (meta_due && (s_rows[m_slot] == 0 || s_cols[m_slot] == 0)) done_due = 1;
         if (bus.read_data_valid && m_idx == int'(s_rows[m_slot]) * int'(s_cols[m_slot]))
            done_due = 1;
         meta_due = bus.read_req;
         if (bus.read_req) begin
            m_slot = int'(bus.read_matrix_id);
            m_idx  = 0;
         end
         data_due  = bus.read_data_req;
         pend_push = bus.read_data_valid ? 1 : 0;
      end
   end

   task automatic clear_obs();
      rcv.delete();
      meta_cnt = 0; req_cnt = 0; dreq_cnt = 0; overfill = 0; stab_viol = 0;
   endtask

   task automatic start_cmd(input int id);
      @(negedge clk);
      bus.cmd_valid     = 1'b1;
      bus.cmd_matrix_id = 3'(id);
      @(negedge clk);
      bus.cmd_valid     = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int max_cyc);
      int k = 0;
      while (busy && k < max_cyc) begin
         @(negedge clk);
         k++;
      end
      check(tag, busy, 0);
   endtask

   task automatic check_stream(input int slot);
      int n = int'(s_rows[slot]) * int'(s_cols[slot]);
      int c = int'(s_cols[slot]);
      check("beat_count", rcv.size(), n);
      for (int i = 0; i < n && i < rcv.size(); i++)
         check($sformatf("beat%0d", i), rcv[i],
               64'({elem_val(slot, i), 8'(i / c), 8'(i % c), (i == n - 1)}));
   endtask

   initial begin
      int k;
      for (int i = 0; i < 8; i++) begin
         s_rows[i] = 8'd1; s_cols[i] = 8'd1; s_name[i] = '0; s_silent[i] = 0;
      end
      s_rows[0] = 8'd3; s_cols[0] = 8'd3; s_name[0] = "Matrix_A";
      s_rows[1] = 8'd2; s_cols[1] = 8'd4; s_name[1] = "Matrix_B";
      s_rows[2] = 8'd0; s_cols[2] = 8'd3; s_name[2] = "Empty_Mx";
      s_rows[3] = 8'd2; s_cols[3] = 8'd2; s_name[3] = "Silent_M"; s_silent[3] = 1;
      m_slot = 0; m_idx = 0;
      bus.cmd_valid = 1'b0; bus.cmd_matrix_id = '0; bus.reader_ready = 1'b1;
      ready_mode = 1;
      clear_obs();

      repeat (3) @(negedge clk);
      check("rst_cmd_ready", bus.cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_error", error, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_meta", {bus.meta_valid, bus.meta_rows, bus.meta_cols}, 0);
      rst = 1'b0;

      // 3x3 stream, REQ held off by reader_ready for a few cycles
      bus.reader_ready = 1'b0;
      start_cmd(0);
      repeat (3) @(negedge clk);
      check("t1_req_waits", req_cnt, 0);
      bus.reader_ready = 1'b1;
      wait_idle("t1_idle", 200);
      check("t1_req_cnt", req_cnt, 1);
      check("t1_meta_cnt", meta_cnt, 1);
      check("t1_meta_dims", {got_rows, got_cols}, {8'd3, 8'd3});
      check("t1_meta_name", got_name, "Matrix_A");
      check_stream(0);

      // 2x4 stream with backpressure, cmd_valid held while busy
      clear_obs();
      ready_mode = 2;
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_matrix_id = 3'd1;
      @(negedge clk);
      bus.cmd_matrix_id = 3'd5;
      repeat (6) @(negedge clk);
      check("t2_cmd_ready_busy", bus.cmd_ready, 0);
      check("t2_one_req", req_cnt, 1);
      bus.cmd_valid = 1'b0;
      wait_idle("t2_idle", 400);
      check("t2_req_cnt", req_cnt, 1);
      check("t2_meta_dims", {got_rows, got_cols}, {8'd2, 8'd4});
      check("t2_overfill", overfill, 0);
      check("t2_stable", stab_viol, 0);
      check_stream(1);

      // Manager never returns data -> timeout
      clear_obs();
      ready_mode = 1;
      start_cmd(3);
      k = 0;
      while (dreq_cnt == 0 && k < 60) begin @(negedge clk); k++; end
      check("t4_dreq_seen", dreq_cnt, 1);
      k = 0;
      while (!error && k < 60) begin @(negedge clk); k++; end
      check("t4_error_time", (k >= 15 && k <= 19), 1);
      wait_idle("t4_idle", 10);
      check("t4_error", error, 1);
      check("t4_cmd_ready", bus.cmd_ready, 1);
      check("t4_no_beats", rcv.size(), 0);

      // rows == 0: metadata only; the accepted command clears the sticky error
      clear_obs();
      start_cmd(2);
      check("t3_error_cleared", error, 0);
      wait_idle("t3_idle", 60);
      check("t3_meta_cnt", meta_cnt, 1);
      check("t3_meta_rows", got_rows, 0);
      check("t3_no_dreq", dreq_cnt, 0);
      check("t3_no_beats", rcv.size(), 0);

      // Reset in the middle of a stalled stream
      clear_obs();
      ready_mode = 0;
      start_cmd(0);
      repeat (12) @(negedge clk);
      check("t5_fifo_holding", bus.out_valid, 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("t5_rst_out_valid", bus.out_valid, 0);
      check("t5_rst_busy", busy, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_obs();
      ready_mode = 1;
      start_cmd(0);
      wait_idle("t5_idle", 200);
      check("t5_meta_cnt", meta_cnt, 1);
      check_stream(0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1);
   end

endmodule

`default_nettype wire
